// File: rtl/dot_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot_seq_pkg
// Purpose  : Shared definitions for the dot-product operand sequencer:
//            data width, default length width and the FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dot_seq_pkg;

  localparam int DW            = 32;  // multiplier operand / sum width
  localparam int LEN_W_DEFAULT = 8;   // default vector-length width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dot_product_seq.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_seq
// Purpose  : Operand sequencer for a registered X*Y+Z multiplier. Pulls
//            element pairs over a valid/ready stream, feeds the previous
//            product back as Z, and returns the final sum plus a sticky
//            overflow flag over a valid/ready result port.
// Ports    : clock, reset (async, active-low)
//            start/len/bias          - command, sampled in IDLE only
//            in_valid/in_ready/in_x/in_y - element pair stream
//            mul_x/mul_y/mul_z/mul_iso   - drive to multiplier
//            mul_prod/mul_ovfl           - registered multiplier results
//            res_valid/res_ready/res_data/res_ovfl - result port
//            busy                    - high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_seq
  import dot_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [DW-1:0]    bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_x,
  input  logic [DW-1:0]    in_y,
  output logic [DW-1:0]    mul_x,
  output logic [DW-1:0]    mul_y,
  output logic [DW-1:0]    mul_z,
  output logic             mul_iso,
  input  logic [DW-1:0]    mul_prod,
  input  logic             mul_ovfl,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic             res_ovfl,
  output logic             busy
);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [DW-1:0]    r_opx;
  logic [DW-1:0]    r_opy;
  logic [DW-1:0]    r_acc;
  logic             r_ovfl;
  logic [DW-1:0]    r_mul_z;
  logic             r_mul_iso;
  logic             r_in_ready;
  logic             r_res_valid;
  logic [DW-1:0]    r_res_data;
  logic             r_res_ovfl;
  logic             r_busy;

  // Every output is a register updated on the state transition that enters
  // the state in which it must be asserted. The operand registers are only
  // non-zero during MUL, so they drive the multiplier directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_opx       <= '0;
      r_opy       <= '0;
      r_acc       <= '0;
      r_ovfl      <= 1'b0;
      r_mul_z     <= '0;
      r_mul_iso   <= 1'b1;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ovfl  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc  <= bias;
            r_ovfl <= 1'b0;
            r_cnt  <= len;
            r_busy <= 1'b1;
            if (len == '0) begin
              // Empty vector: the result is the bias itself.
              r_state     <= ST_DONE;
              r_res_valid <= 1'b1;
              r_res_data  <= bias;
              r_res_ovfl  <= 1'b0;
            end else begin
              r_state    <= ST_LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (in_valid) begin
            r_opx      <= in_x;
            r_opy      <= in_y;
            r_mul_z    <= r_acc;
            r_mul_iso  <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MUL;
          end
        end

        ST_MUL: begin
          // The multiplier captures X*Y+Z at the end of this cycle; quiet
          // its inputs again for every other state.
          r_opx     <= '0;
          r_opy     <= '0;
          r_mul_z   <= '0;
          r_mul_iso <= 1'b1;
          r_state   <= ST_ACC;
        end

        ST_ACC: begin
          r_acc  <= mul_prod;
          r_ovfl <= r_ovfl | mul_ovfl;
          r_cnt  <= r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            r_state     <= ST_DONE;
            r_res_valid <= 1'b1;
            r_res_data  <= mul_prod;
            r_res_ovfl  <= r_ovfl | mul_ovfl;
          end else begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ovfl  <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mul_x     = r_opx;
  assign mul_y     = r_opy;
  assign mul_z     = r_mul_z;
  assign mul_iso   = r_mul_iso;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_ovfl  = r_res_ovfl;
  assign busy      = r_busy;

endmodule
`default_nettype wire
